// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline shift/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } pipeline_state_t;

  localparam int CTRL_W = 32;
  // Control word injected into ID_EX when a bubble is inserted.
  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// I-cache / D-cache handshake bundle between the controller and the caches.
interface pipeline_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_resp;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_read;
  logic            dmem_resp;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_read;
  logic            dmem_write;

  modport master (
    input  imem_resp, imem_rdata, dmem_resp, dmem_rdata,
    output imem_read, dmem_read, dmem_write
  );

  modport slave (
    output imem_resp, imem_rdata, dmem_resp, dmem_rdata,
    input  imem_read, dmem_read, dmem_write
  );
endinterface

// File: rtl/pipeline_ctrl_resp_latch.sv
// Holds one early cache response (valid flag + data) until the pipeline advances.
module pipeline_ctrl_resp_latch
  import pipeline_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         capture,
  input  logic         clear,
  input  logic [W-1:0] d_in,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= d_in;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline advance/hold/bubble/flush control between the cache handshakes and
// the datapath stage registers, with stall and flush performance counters.
//
// state | meaning
// RUN   | no cache response held
// WAIT  | one response held (i_done or d_done set), waiting for the other port
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  pipeline_ctrl_if.master   bus,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_br_taken,
  output logic [XLEN-1:0]   ir_out,
  output logic [XLEN-1:0]   mem_rdata_out,
  output logic              load_pipe,
  output logic              load_front,
  output logic              bubble,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pipeline_state_t state, next_state;

  logic            i_done, d_done;
  logic [XLEN-1:0] held_ir, held_rd;
  logic            need_d, i_ok, d_ok, hz;
  logic            cap_i, cap_d;

  always_comb begin
    need_d    = mem_rd_req | mem_wr_req;
    i_ok      = bus.imem_resp | i_done;
    d_ok      = !need_d | bus.dmem_resp | d_done;
    load_pipe = reset_n & i_ok & d_ok;
    // A lone response during a stall is kept so that port is not re-requested.
    cap_i     = bus.imem_resp & !i_done & !load_pipe;
    cap_d     = bus.dmem_resp & !d_done & !load_pipe;
    hz        = ex_is_load & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

  pipeline_ctrl_resp_latch #(.W(XLEN)) u_i_latch (
    .clk     (clk),
    .reset_n (reset_n),
    .capture (cap_i),
    .clear   (load_pipe),
    .d_in    (bus.imem_rdata),
    .valid   (i_done),
    .data    (held_ir)
  );

  pipeline_ctrl_resp_latch #(.W(XLEN)) u_d_latch (
    .clk     (clk),
    .reset_n (reset_n),
    .capture (cap_d),
    .clear   (load_pipe),
    .d_in    (bus.dmem_rdata),
    .valid   (d_done),
    .data    (held_rd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (cap_i | cap_d) next_state = WAIT;
      WAIT:    if (load_pipe)     next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    bus.imem_read  = reset_n & !i_done;
    bus.dmem_read  = reset_n & mem_rd_req & !d_done;
    bus.dmem_write = reset_n & mem_wr_req & !d_done;
    flush          = load_pipe & ex_br_taken;
    bubble         = load_pipe & hz & !ex_br_taken;
    load_front     = load_pipe & !bubble;
    ir_out         = i_done ? held_ir : bus.imem_rdata;
    mem_rdata_out  = d_done ? held_rd : bus.dmem_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!load_pipe) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush)      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // A second response on a port whose result is already held is a cache protocol error.
  a_no_dup_iresp: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.imem_resp && i_done));
  a_no_dup_dresp: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.dmem_resp && d_done));
  a_wait_has_flag: assert property (@(posedge clk) disable iff (!reset_n)
    (state == WAIT) == (i_done || d_done));

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// cache/hazard traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             mem_rd_req, mem_wr_req;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_is_load, ex_br_taken;
  logic [XLEN-1:0]  ir_out, mem_rdata_out;
  logic             load_pipe, load_front, bubble, flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl_if #(.XLEN(XLEN)) bus();

  pipeline_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .mem_rd_req    (mem_rd_req),
    .mem_wr_req    (mem_wr_req),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_rd         (ex_rd),
    .ex_is_load    (ex_is_load),
    .ex_br_taken   (ex_br_taken),
    .ir_out        (ir_out),
    .mem_rdata_out (mem_rdata_out),
    .load_pipe     (load_pipe),
    .load_front    (load_front),
    .bubble        (bubble),
    .flush         (flush),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Model: which responses have already been collected for the current advance.
  bit          have_ir, have_rd;
  logic [31:0] keep_ir, keep_rd;
  int unsigned m_stall, m_flush;
  bit          adv_now, flush_now;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = $urandom;
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = $urandom;
    mem_rd_req     = 1'b0;
    mem_wr_req     = 1'b0;
    id_rs1         = 5'd0;
    id_rs2         = 5'd0;
    ex_rd          = 5'd0;
    ex_is_load     = 1'b0;
    ex_br_taken    = 1'b0;
  endtask

  // Let inputs settle, then compare every output against the model.
  task automatic settle();
    bit need, instr_ready, data_ready, hazard, e_bubble;
    #1;
    if (!reset_n) begin
      have_ir = 0; have_rd = 0; keep_ir = '0; keep_rd = '0;
      m_stall = 0; m_flush = 0;
    end
    need        = mem_rd_req || mem_wr_req;
    instr_ready = bus.imem_resp || have_ir;
    data_ready  = !need || bus.dmem_resp || have_rd;
    adv_now     = reset_n && instr_ready && data_ready;
    hazard      = ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    flush_now   = adv_now && ex_br_taken;
    e_bubble    = adv_now && hazard && !ex_br_taken;
    chk("imem_read",  bus.imem_read,  reset_n && !have_ir);
    chk("dmem_read",  bus.dmem_read,  reset_n && mem_rd_req && !have_rd);
    chk("dmem_write", bus.dmem_write, reset_n && mem_wr_req && !have_rd);
    chk("load_pipe",  load_pipe,  adv_now);
    chk("load_front", load_front, adv_now && !e_bubble);
    chk("bubble",     bubble,     e_bubble);
    chk("flush",      flush,      flush_now);
    chk("ir_out",     ir_out,     have_ir ? keep_ir : bus.imem_rdata);
    chk("mem_rdata",  mem_rdata_out, have_rd ? keep_rd : bus.dmem_rdata);
    chk("stall_cnt",  stall_cnt,  m_stall);
    chk("flush_cnt",  flush_cnt,  m_flush);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      if (adv_now) begin
        have_ir = 0;
        have_rd = 0;
      end else begin
        if (bus.imem_resp && !have_ir) begin have_ir = 1; keep_ir = bus.imem_rdata; end
        if (bus.dmem_resp && !have_rd) begin have_rd = 1; keep_rd = bus.dmem_rdata; end
      end
      if (!adv_now)  m_stall = (m_stall + 1) % (1 << CNT_W);
      if (flush_now) m_flush = (m_flush + 1) % (1 << CNT_W);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    settle();
    chk("rst_imem_read", bus.imem_read, 1'b0);
    chk("rst_load_pipe", load_pipe, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    bit new_req;
    int r;
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    do_reset();

    // Fetch-only traffic: the pipe advances every cycle.
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.imem_resp = 1'b1;
      bus.imem_rdata = 32'h0000_0013;
      settle();
      chk("fetch_lp", load_pipe, 1'b1);
      chk("fetch_ir", ir_out, 32'h0000_0013);
      chk("fetch_stall", stall_cnt, 0);
      tick();
    end

    // Store in MEM: instruction arrives in cycle 1, store completes in cycle 4.
    idle();
    mem_wr_req = 1'b1;
    bus.imem_resp = 1'b1;
    bus.imem_rdata = 32'hABCD_0001;
    settle();
    chk("st_c1_lp", load_pipe, 1'b0);
    tick();
    for (int c = 2; c <= 4; c++) begin
      idle();
      mem_wr_req = 1'b1;
      bus.dmem_resp = (c == 4);
      settle();
      chk("st_imem_read", bus.imem_read, 1'b0);
      chk("st_ir_held", ir_out, 32'hABCD_0001);
      chk("st_dmem_write", bus.dmem_write, 1'b1);
      chk("st_lp", load_pipe, c == 4);
      tick();
    end
    idle();
    settle();
    chk("st_stall_cnt", stall_cnt, 3);
    chk("st_reissue", bus.imem_read, 1'b1);
    tick();

    // Load-use hazard with both responses present.
    idle();
    bus.imem_resp = 1'b1;
    mem_rd_req = 1'b1;
    bus.dmem_resp = 1'b1;
    ex_is_load = 1'b1;
    ex_rd = 5'd5;
    id_rs1 = 5'd1;
    id_rs2 = 5'd5;
    settle();
    chk("hz_bubble", bubble, 1'b1);
    chk("hz_front", load_front, 1'b0);
    chk("hz_lp", load_pipe, 1'b1);
    tick();
    idle();
    bus.imem_resp = 1'b1;
    ex_rd = 5'd5;
    id_rs2 = 5'd5;
    settle();
    chk("hz_clear_bubble", bubble, 1'b0);
    chk("hz_refetch", bus.imem_read, 1'b1);
    tick();

    // Taken branch overrides the hazard bubble.
    idle();
    bus.imem_resp = 1'b1;
    ex_is_load = 1'b1;
    ex_rd = 5'd7;
    id_rs1 = 5'd7;
    ex_br_taken = 1'b1;
    settle();
    chk("br_flush", flush, 1'b1);
    chk("br_bubble", bubble, 1'b0);
    chk("br_front", load_front, 1'b1);
    tick();
    idle();
    settle();
    chk("br_flush_cnt", flush_cnt, 1);
    tick();

    // Reset while a load result is held.
    idle();
    bus.imem_resp = 1'b0;
    mem_rd_req = 1'b1;
    bus.dmem_resp = 1'b1;
    bus.dmem_rdata = 32'h0000_5A5A;
    settle();
    tick();
    idle();
    mem_rd_req = 1'b1;
    settle();
    chk("wait_dmem_read", bus.dmem_read, 1'b0);
    chk("wait_rdata", mem_rdata_out, 32'h0000_5A5A);
    tick();
    reset_n = 1'b0;
    mem_rd_req = 1'b1;
    settle();
    chk("mid_rst_dmem_read", bus.dmem_read, 1'b0);
    chk("mid_rst_stall", stall_cnt, 0);
    tick();
    reset_n = 1'b1;
    mem_rd_req = 1'b1;
    settle();
    chk("post_rst_dmem_read", bus.dmem_read, 1'b1);
    chk("post_rst_imem_read", bus.imem_read, 1'b1);
    tick();

    // Stall counter wraps at 2^CNT_W.
    do_reset();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      idle();
      settle();
      tick();
    end
    idle();
    settle();
    chk("wrap_all_ones", stall_cnt, 8'hFF);
    tick();
    idle();
    settle();
    chk("wrap_zero", stall_cnt, 0);
    tick();

    // Randomized cache timing, hazards and branches.
    do_reset();
    new_req = 1;
    for (int i = 0; i < 1500; i++) begin
      if (new_req) begin
        r = $urandom % 4;
        mem_rd_req = (r == 0);
        mem_wr_req = (r == 1);
      end
      bus.imem_rdata = $urandom;
      bus.dmem_rdata = $urandom;
      bus.imem_resp  = !have_ir && ($urandom % 3 != 0);
      bus.dmem_resp  = (mem_rd_req || mem_wr_req) && !have_rd && ($urandom % 2 == 0);
      id_rs1      = 5'($urandom % 4);
      id_rs2      = 5'($urandom % 4);
      ex_rd       = 5'($urandom % 4);
      ex_is_load  = ($urandom % 2 == 0);
      ex_br_taken = ($urandom % 6 == 0);
      settle();
      new_req = adv_now;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Drives the shift/flush side of the pipeline stage registers: it decides each cycle whether the PC/IR/control-word shift chains advance, hold, take a bubble or flush.
- Sits between the I/D cache handshakes and the datapath stage registers.
- Latches a cache response that arrives while the other port is still pending, so no access is ever issued twice.
- Keeps stall and flush performance counters.

Parameters:
- XLEN, 32, data/instruction width
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- imem_resp  in  1  I-cache response valid (single-cycle pulse)
- imem_rdata  in  XLEN  I-cache instruction
- imem_read  out  1  I-cache request
- mem_rd_req  in  1  MEM-stage control word requests a load
- mem_wr_req  in  1  MEM-stage control word requests a store
- dmem_resp  in  1  D-cache response valid (pulse)
- dmem_rdata  in  XLEN  D-cache load data
- dmem_read  out  1  gated D-cache read request
- dmem_write  out  1  gated D-cache write request
- id_rs1, id_rs2  in  5 each  source registers decoded in ID
- ex_rd  in  5  destination register in EX
- ex_is_load  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch or jump
- ir_out  out  XLEN  instruction presented to the IR shift chain input
- mem_rdata_out  out  XLEN  load data presented to the MEM_WB stage
- load_pipe  out  1  shift enable for the EX_MEM and MEM_WB stages
- load_front  out  1  shift enable for the PC and IF_ID stages
- bubble  out  1  replace ID_EX control word with all-zero NOP
- flush  out  1  zero the IF_ID and ID_EX stages
- stall_cnt  out  CNT_W  cycles with load_pipe=0
- flush_cnt  out  CNT_W  flush events

Behaviour:
- Reset (async, reset_n=0): state=RUN; i_done=0, d_done=0; held_ir=0, held_rd=0; both counters=0. All request and enable outputs are 0 while in reset.
- States:
  - RUN: no response held.
  - WAIT: at least one response held; i_done and/or d_done is set.
- Definitions:
  - need_d = mem_rd_req | mem_wr_req
  - i_ok = imem_resp | i_done
  - d_ok = !need_d | dmem_resp | d_done
- Requests:
  - imem_read = !i_done
  - dmem_read = mem_rd_req & !d_done
  - dmem_write = mem_wr_req & !d_done
- Advance: load_pipe = i_ok & d_ok, combinational with zero added latency.
- Latching: if exactly one of imem_resp/dmem_resp arrives and load_pipe=0, capture imem_rdata into held_ir (or dmem_rdata into held_rd), set i_done (or d_done), and go to WAIT.
- Completion: on load_pipe=1, clear i_done and d_done and go to RUN.
- Data outputs: ir_out = i_done ? held_ir : imem_rdata. mem_rdata_out uses the same selection on d_done.
- Load-use hazard: hz = ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - If load_pipe & hz & !ex_br_taken: bubble=1, load_front=0, and the fetched instruction is discarded.
  - imem_read is reissued the next cycle for the same PC.
- Flush: if load_pipe & ex_br_taken, then flush=1, bubble=0, load_front=1 (PC takes the redirect). Flush has priority over bubble.
- Otherwise load_front = load_pipe, bubble=0, flush=0.
- bubble and flush are only ever asserted in cycles where load_pipe=1.
- Counters:
  - stall_cnt increments each cycle load_pipe=0.
  - flush_cnt increments each cycle flush=1.
  - Both wrap modulo 2^CNT_W.
- Simultaneous responses: imem_resp and dmem_resp in the same cycle give load_pipe=1; nothing is latched.
- A response arriving in WAIT for the not-yet-done port completes the advance that cycle.
- Responses while the corresponding done flag is already set are protocol errors; assert in simulation and ignore.
- reset_n deasserted mid-WAIT discards held data; the next request is reissued from RUN.

Decomposition:
- Shared package gets the NOP control-word constant (all zero) and the pipeline_state_t enum {RUN, WAIT}.
- One natural sub-module: resp_latch (valid flag plus data register with clear). It is instantiated twice, for the I-port and the D-port.

Test Plan:
- No D-access, imem_resp every cycle with 0x00000013 -> load_pipe=1 each cycle, stall_cnt=0, ir_out=0x00000013.
- Store in MEM: imem_resp at cycle 1, dmem_resp at cycle 4 ->
  - i_done=1 from cycle 2; imem_read=0 in cycles 2-4.
  - ir_out = held value; load_pipe=1 only at cycle 4; stall_cnt=3.
- EX load with ex_rd=5 and id_rs2=5, both responses present -> bubble=1, load_front=0, load_pipe=1. Next cycle with ex_is_load=0 -> bubble=0.
- ex_br_taken together with hazard and responses -> flush=1, bubble=0, load_front=1, flush_cnt increments by 1.
- Assert reset_n=0 in WAIT with d_done=1 -> state=RUN, flags clear, counters 0. After release, dmem_read reasserts if mem_rd_req=1.
- Force stall_cnt to all-ones with load_pipe=0 for one cycle -> wraps to 0.
